// File: rtl/instr_stack.sv
// instr_stack: hardware return-address stack for CAL/RET/interrupt entry.
// Optional sticky overflow/underflow flag enabled by macro ISP_ERR_EN.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push, pop    : requests from prefetch isp_push / isp_pop
//   addr_in      : return address to save
//   addr_out     : top-of-stack entry (0 when empty), registered-state only
//   depth        : number of valid entries, 0..SDEPTH
//   empty, full  : occupancy flags decoded from depth
//   err          : sticky overflow/underflow flag (0 without ISP_ERR_EN)
module instr_stack #(
    parameter int MINSTW = 8,
    parameter int SDEPTH = 8,
    localparam int SPTRW = $clog2(SDEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [MINSTW-1:0] addr_in,
    output logic [MINSTW-1:0] addr_out,
    output logic [SPTRW-1:0]  depth,
    output logic              empty,
    output logic              full,
    output logic              err
);

    localparam int AW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

    logic [MINSTW-1:0] mem_q [SDEPTH];
    logic [MINSTW-1:0] mem_d [SDEPTH];
    logic [SPTRW-1:0]  sp_q;
    logic [SPTRW-1:0]  sp_d;

    logic [AW-1:0] top_idx;
    logic [AW-1:0] nxt_idx;

    // Mutually exclusive request classes.
    logic rep_ev;
    logic psh_ev;
    logic pop_ev;
    logic ovf_ev;
    logic unf_ev;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SPTRW'(SDEPTH));
    assign depth   = sp_q;
    assign top_idx = AW'(sp_q - SPTRW'(1));
    assign nxt_idx = AW'(sp_q);

    assign addr_out = empty ? '0 : mem_q[top_idx];

    // Push+pop on an empty stack degrades to a plain push.
    assign rep_ev = push & pop & ~empty;
    assign psh_ev = push & ~rep_ev & ~full;
    assign ovf_ev = push & ~rep_ev & full;
    assign pop_ev = pop & ~push & ~empty;
    assign unf_ev = pop & ~push & empty;

    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        unique case (1'b1)
            rep_ev: mem_d[top_idx] = addr_in;
            psh_ev: begin
                mem_d[nxt_idx] = addr_in;
                sp_d           = sp_q + SPTRW'(1);
            end
            pop_ev: sp_d = sp_q - SPTRW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Contents need no reset: nothing reads them while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef ISP_ERR_EN
    logic err_q;
    logic err_d;

    assign err_d = err_q | ovf_ev | unf_ev;
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_ev;

    assign unused_ev = ovf_ev | unf_ev;
    assign err       = 1'b0;
`endif

endmodule

// File: doc/instr_stack.md
# instr_stack

Hardware return-address stack that responds to the `isp_push`/`isp_pop` requests issued by the instruction prefetch stage on CAL, RET and interrupt entry. A push saves the supplied return address, and a pop removes it. The current top of stack is always presented combinationally, so the PC can load the return address in the same cycle the RET is decoded. The block sits beside the program counter in the processor core, with its push/pop inputs driven by the prefetch decode.

## Interface
- `MINSTW`, 8: instruction address width, in bits.
- `SDEPTH`, 8: number of stack entries, minimum 2.
- `SPTRW`, `$clog2(SDEPTH+1)`: width of the occupancy count. Derived; do not override.
- `clk`  in  1: system clock. All state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `push`  in  1: push request, from prefetch `isp_push`.
- `pop`  in  1: pop request, from prefetch `isp_pop`.
- `addr_in`  in  MINSTW: return address to save, normally PC+1 (or the interrupted PC for `itr`).
- `addr_out`  out  MINSTW: current top-of-stack entry, combinational.
- `depth`  out  SPTRW: number of valid entries, 0..SDEPTH.
- `empty`  out  1: asserted when `depth == 0`.
- `full`  out  1: asserted when `depth == SDEPTH`.
- `err`  out  1: sticky overflow/underflow flag. Tied 0 when `ISP_ERR_EN` is undefined.

## Operation
- Storage is an array `mem[0..SDEPTH-1]` of MINSTW-bit registers plus a pointer `sp` (SPTRW bits) equal to `depth`.
- `addr_out` is `mem[sp-1]` when `sp != 0`, and 0 when empty. It is a pure function of the registered state, with no combinational path from `push` or `pop`.
- Request decoding, all on the clock edge:
  - push only, not full: `mem[sp] <= addr_in`, `sp <= sp+1`.
  - pop only, not empty: `sp <= sp-1`. Memory is untouched.
  - push and pop together, not empty: `mem[sp-1] <= addr_in`, `sp` unchanged. This is a replace-top.
  - push and pop together, empty: treated as push only. `mem[0] <= addr_in`, `sp <= 1`.
  - push when full: write discarded, `sp` stays at SDEPTH, top unchanged. This is an overflow event.
  - pop when empty: no state change, `addr_out` stays 0. This is an underflow event.
  - neither request: hold.
- `sp` never wraps. It saturates at 0 and at SDEPTH.
- Reset sets `sp` to 0 and `err` to 0. The contents of `mem` need not be cleared, because nothing reads them while empty.
- Reset values: `addr_out` 0, `depth` 0, `empty` 1, `full` 0, `err` 0.
- Reset wins over any simultaneous push/pop. A reset asserted mid-sequence discards the whole stack in one cycle.

## Timing
- Push and pop take effect at the edge where they are sampled. `addr_out`, `depth`, `empty` and `full` reflect the new state one cycle later.
- RET timing: `addr_out` is valid in the cycle RET is decoded, since it reflects pushes from earlier cycles. The pop edge and the PC load edge are the same edge.
- Back-to-back pushes and pops are sustained every cycle, with no bubbles.
- `full` and `empty` are decoded from `sp`. There is no extra latency.
- `err` rises one cycle after the offending edge and stays high until `rst`.

## Configuration
- `ISP_ERR_EN` defined: overflow and underflow events set `err` (sticky). This lets the simulation bench or a debug port catch recursion deeper than SDEPTH or an unbalanced RET. Storage behaviour is unchanged: the write is still discarded and the pointer still saturates.
- `ISP_ERR_EN` undefined: no error logic is synthesised and `err` is constant 0. All other behaviour is identical.

## Test plan
- Reset, then push `addr_in`=0x12, 0x34, 0x56 on consecutive cycles -> `depth` reaches 3 and `addr_out`=0x56. Then 3 pops -> `addr_out` reads 0x34, 0x12, 0 and `empty`=1.
- SDEPTH=8: push 0x01..0x08, then push 0x99 -> `full`=1, `depth`=8, `addr_out`=0x08. With `ISP_ERR_EN` defined, `err`=1 from the next cycle.
- On an empty stack, pop -> `depth`=0 and `addr_out`=0. `err`=1 only with `ISP_ERR_EN` defined.
- Stack holding {0x10, 0x20}, assert push+pop with `addr_in`=0x77 -> `depth` stays 2 and `addr_out`=0x77. On an empty stack, push+pop with 0x44 -> `depth`=1 and `addr_out`=0x44.
- Push 0x0A, 0x0B, assert `rst` together with push 0x0C, then pop -> `depth`=0, `addr_out`=0 and `err`=0 after reset. The pop after reset is an underflow, so `err`=1 with the macro defined.
- Random push/pop stream of 2000 cycles, checked against a behavioural stack model -> `addr_out`, `depth`, `full` and `empty` match the model every cycle.
